// File: rtl/game_pacman_unit.sv
// Pac-Man movement engine: pixel position, heading, relative turn latch and
// mouth animation, stepped once per 60 Hz tick against a procedural maze.
module game_pacman_unit #(
  parameter int MAZE_W   = 28,
  parameter int MAZE_H   = 31,
  parameter int SPAWN_X  = 13,
  parameter int SPAWN_Y  = 23,
  parameter int ANIM_DIV = 4
) (
  input  logic       clk60,
  input  logic       reset,
  input  logic       start,
  input  logic       left,
  input  logic       right,
  input  logic       uturn,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [1:0] dir,
  output logic [6:0] curr_xtile,
  output logic [6:0] curr_ytile,
  output logic [1:0] animation_state
);

  // state | meaning
  // IDLE  | position frozen, controls ignored
  // RUN   | moving, steering accepted
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] PEND_NONE  = 2'd0;
  localparam logic [1:0] PEND_LEFT  = 2'd1;
  localparam logic [1:0] PEND_RIGHT = 2'd2;

  localparam int CNT_W = $clog2(ANIM_DIV + 1);

  logic [0:0]       state_q, state_d;
  logic [9:0]       xloc_q, xloc_d;
  logic [9:0]       yloc_q, yloc_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       anim_q, anim_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  logic       centred;
  logic [1:0] target;
  logic [1:0] move_dir;
  logic       move;
  logic       turned;

  // Tiles are widened to 8 bits so a step off tile 0 wraps out of range (wall).
  function automatic logic tile_open(input logic [7:0] tx, input logic [7:0] ty);
    tile_open = (tx >= 8'd1) && (tx <= 8'(MAZE_W - 2)) &&
                (ty >= 8'd1) && (ty <= 8'(MAZE_H - 2)) && (tx[0] | ty[0]);
  endfunction

  function automatic logic ahead_open(input logic [6:0] tx, input logic [6:0] ty,
                                      input logic [1:0] d);
    logic [7:0] nx;
    logic [7:0] ny;
    nx = {1'b0, tx};
    ny = {1'b0, ty};
    case (d)
      2'b00:   nx = nx + 8'd1;
      2'b01:   ny = ny - 8'd1;
      2'b10:   nx = nx - 8'd1;
      default: ny = ny + 8'd1;
    endcase
    ahead_open = tile_open(nx, ny);
  endfunction

  assign centred = (xloc_q[2:0] == 3'd0) && (yloc_q[2:0] == 3'd0);
  assign target  = (pend_q == PEND_LEFT) ? dir_q + 2'd1 : dir_q - 2'd1;

  always_comb begin
    state_d   = state_q;
    xloc_d    = xloc_q;
    yloc_d    = yloc_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    anim_d    = anim_q;
    pix_cnt_d = pix_cnt_q;
    move      = 1'b0;
    turned    = 1'b0;
    move_dir  = dir_q;

    if (state_q == ST_IDLE) begin
      if (start) state_d = ST_RUN;
    end else begin
      // A same-edge uturn takes precedence over applying a pending turn.
      if (!centred) begin
        move = 1'b1;
      end else if (!uturn && pend_q != PEND_NONE &&
                   ahead_open(xloc_q[9:3], yloc_q[9:3], target)) begin
        move     = 1'b1;
        turned   = 1'b1;
        move_dir = target;
      end else if (ahead_open(xloc_q[9:3], yloc_q[9:3], dir_q)) begin
        move = 1'b1;
      end

      if (move) begin
        case (move_dir)
          2'b00:   xloc_d = xloc_q + 10'd1;
          2'b01:   yloc_d = yloc_q - 10'd1;
          2'b10:   xloc_d = xloc_q - 10'd1;
          default: yloc_d = yloc_q + 10'd1;
        endcase
        if (pix_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
          pix_cnt_d = '0;
          anim_d    = anim_q + 2'd1;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end

      if (uturn)       dir_d = dir_q ^ 2'b10;
      else if (turned) dir_d = target;

      if (uturn)               pend_d = PEND_NONE;
      else if (left && !right) pend_d = PEND_LEFT;
      else if (right && !left) pend_d = PEND_RIGHT;
      else if (turned)         pend_d = PEND_NONE;
    end
  end

  always_ff @(posedge clk60 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      xloc_q    <= 10'(SPAWN_X * 8);
      yloc_q    <= 10'(SPAWN_Y * 8);
      dir_q     <= 2'b10;
      pend_q    <= PEND_NONE;
      anim_q    <= 2'd0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      xloc_q    <= xloc_d;
      yloc_q    <= yloc_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      anim_q    <= anim_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign xloc            = xloc_q;
  assign yloc            = yloc_q;
  assign dir             = dir_q;
  assign curr_xtile      = xloc_q[9:3];
  assign curr_ytile      = yloc_q[9:3];
  assign animation_state = anim_q;

endmodule

// File: tb/tb_game_pacman_unit.sv
// Bench for game_pacman_unit: integer-level movement model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_game_pacman_unit;

  logic       clk60 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic       uturn = 1'b0;
  logic [9:0] xloc, yloc;
  logic [1:0] dir;
  logic [6:0] curr_xtile, curr_ytile;
  logic [1:0] animation_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  game_pacman_unit dut (
    .clk60           (clk60),
    .reset           (reset),
    .start           (start),
    .left            (left),
    .right           (right),
    .uturn           (uturn),
    .xloc            (xloc),
    .yloc            (yloc),
    .dir             (dir),
    .curr_xtile      (curr_xtile),
    .curr_ytile      (curr_ytile),
    .animation_state (animation_state)
  );

  always #5 clk60 = ~clk60;

  // Model: pixel coordinates as ints, pending turn as +1 (left) / -1 (right) / 0.
  int DX [4] = '{1, 0, -1, 0};
  int DY [4] = '{0, -1, 0, 1};
  bit m_run   = 1'b0;
  int m_x     = 104;
  int m_y     = 184;
  int m_dir   = 2;
  int m_pend  = 0;
  int m_moved = 0;

  function automatic bit m_open(int tx, int ty);
    if (tx < 1 || tx > 26 || ty < 1 || ty > 29) return 1'b0;
    return (tx % 2 == 1) || (ty % 2 == 1);
  endfunction

  task automatic m_reset();
    m_run = 1'b0; m_x = 104; m_y = 184; m_dir = 2; m_pend = 0; m_moved = 0;
  endtask

  task automatic m_step();
    bit cen, mv, turned;
    int tgt, mdir;
    if (!m_run) begin
      if (start) m_run = 1'b1;
      return;
    end
    cen    = (m_x % 8 == 0) && (m_y % 8 == 0);
    tgt    = (m_dir + m_pend + 4) % 4;
    mdir   = m_dir;
    mv     = 1'b0;
    turned = 1'b0;
    if (!cen) mv = 1'b1;
    else if (!uturn && m_pend != 0 && m_open(m_x / 8 + DX[tgt], m_y / 8 + DY[tgt])) begin
      mv = 1'b1; turned = 1'b1; mdir = tgt;
    end else if (m_open(m_x / 8 + DX[m_dir], m_y / 8 + DY[m_dir])) mv = 1'b1;
    if (mv) begin
      m_x = m_x + DX[mdir];
      m_y = m_y + DY[mdir];
      m_moved++;
    end
    if (uturn)       m_dir = (m_dir + 2) % 4;
    else if (turned) m_dir = tgt;
    if (uturn)               m_pend = 0;
    else if (left && !right) m_pend = 1;
    else if (right && !left) m_pend = -1;
    else if (turned)         m_pend = 0;
  endtask

  always @(posedge clk60 or negedge reset) begin
    if (!reset) m_reset();
    else        m_step();
  end

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk60) begin
    if (chk_en) begin
      check("model_xloc", int'(xloc), m_x);
      check("model_yloc", int'(yloc), m_y);
      check("model_dir", int'(dir), m_dir);
      check("model_xtile", int'(curr_xtile), m_x / 8);
      check("model_ytile", int'(curr_ytile), m_y / 8);
      check("model_anim", int'(animation_state), (m_moved / 4) % 4);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk60);
  endtask

  task automatic check_spawn(string tag);
    check({tag, "_xloc"}, int'(xloc), 104);
    check({tag, "_yloc"}, int'(yloc), 184);
    check({tag, "_dir"}, int'(dir), 2);
    check({tag, "_xtile"}, int'(curr_xtile), 13);
    check({tag, "_ytile"}, int'(curr_ytile), 23);
    check({tag, "_anim"}, int'(animation_state), 0);
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic do_reset(string tag);
    @(negedge clk60);
    start = 1'b0; left = 1'b0; right = 1'b0; uturn = 1'b0;
    #2 reset = 1'b0;
    #1 check_spawn(tag);
    @(negedge clk60);
    reset = 1'b1;
    cyc(3);
    check({tag, "_frozen_x"}, int'(xloc), 104);
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    chk_en = 1'b1;
    #2 reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    check_spawn("por");
    cyc(3);
    check("idle_frozen_x", int'(xloc), 104);

    // start, 8 moving edges
    go();
    check("start_edge_nomove", int'(xloc), 104);
    cyc(8);
    check("run8_xloc", int'(xloc), 96);
    check("run8_xtile", int'(curr_xtile), 12);
    check("run8_yloc", int'(yloc), 184);
    check("run8_anim", int'(animation_state), 2);

    // reset mid-motion
    do_reset("rst_mid");

    // run to the left wall
    go();
    cyc(96);
    check("wall_xloc", int'(xloc), 8);
    check("wall_xtile", int'(curr_xtile), 1);
    check("wall_anim", int'(animation_state), 0);
    cyc(5);
    check("wall_hold_xloc", int'(xloc), 8);
    check("wall_hold_anim", int'(animation_state), 0);

    // blocked right turn stays pending until tile 11
    do_reset("rst_turn");
    go();
    cyc(1);
    check("turn_pre_x", int'(xloc), 103);
    right = 1'b1;
    cyc(1);
    right = 1'b0;
    cyc(6);
    check("turn_at96_x", int'(xloc), 96);
    cyc(1);
    check("turn_blocked_x", int'(xloc), 95);
    check("turn_blocked_dir", int'(dir), 2);
    cyc(7);
    check("turn_at88_x", int'(xloc), 88);
    cyc(1);
    check("turn_applied_dir", int'(dir), 1);
    check("turn_applied_y", int'(yloc), 183);
    check("turn_applied_x", int'(xloc), 88);
    cyc(1);
    check("turn_up_y", int'(yloc), 182);

    // uturn off-centre
    do_reset("rst_uturn");
    go();
    cyc(3);
    check("ut_pre_x", int'(xloc), 101);
    uturn = 1'b1;
    cyc(1);
    uturn = 1'b0;
    check("ut_edge_x", int'(xloc), 100);
    check("ut_edge_dir", int'(dir), 0);
    cyc(1);
    check("ut_next_x", int'(xloc), 101);
    cyc(1);
    check("ut_next2_x", int'(xloc), 102);

    // left+right together latches nothing; with uturn only the reversal
    do_reset("rst_both");
    go();
    cyc(2);
    left = 1'b1; right = 1'b1;
    cyc(1);
    left = 1'b0; right = 1'b0;
    check("both_x", int'(xloc), 101);
    cyc(14);
    check("both_pass88_x", int'(xloc), 87);
    check("both_pass88_dir", int'(dir), 2);
    check("both_pass88_y", int'(yloc), 184);
    left = 1'b1; right = 1'b1; uturn = 1'b1;
    cyc(1);
    left = 1'b0; right = 1'b0; uturn = 1'b0;
    check("all3_x", int'(xloc), 86);
    check("all3_dir", int'(dir), 0);
    cyc(3);
    check("all3_pass88_x", int'(xloc), 89);
    check("all3_pass88_dir", int'(dir), 0);
    check("all3_pass88_y", int'(yloc), 184);

    // sparse random steering, checked by the model each cycle
    do_reset("rst_rand");
    go();
    for (int i = 0; i < 600; i++) begin
      left  = ($urandom_range(0, 11) == 0);
      right = ($urandom_range(0, 11) == 0);
      uturn = ($urandom_range(0, 59) == 0);
      cyc(1);
    end
    left = 1'b0; right = 1'b0; uturn = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
